// File: rtl/lob_pkg.sv
// Shared op codes, response status codes and FSM encoding for the order-book dispatcher.
package lob_pkg;
    localparam logic [2:0] OP_ADD        = 3'd0;
    localparam logic [2:0] OP_EXECUTE    = 3'd1;
    localparam logic [2:0] OP_CANCEL     = 3'd2;
    localparam logic [2:0] OP_DELETE     = 3'd3;
    localparam logic [2:0] OP_BEST_LIMIT = 3'd4;
    localparam logic [2:0] OP_VOLUME     = 3'd5;

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_BAD_TYPE = 2'd1;
    localparam logic [1:0] ST_TIMEOUT  = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND} state_t;
endpackage

// File: rtl/lob_op_timer.sv
// Wait timer for an in-flight operation; expired marks the last allowed wait cycle.
module lob_op_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)     r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_en)  r_cnt <= r_cnt + CNT_W'(1);
    end

    assign o_expired = (r_cnt == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/lob_msg_dispatcher.sv
// Launches one order-book operation unit per message, waits for its done (with timeout)
// and returns the unit result plus a status code on a valid/ready response port.
module lob_msg_dispatcher
    import lob_pkg::*;
#(
    parameter int ID_W    = 16,
    parameter int QTY_W   = 16,
    parameter int PX_W    = 16,
    parameter int RES_W   = 16,
    parameter int NUM_OPS = 6,
    parameter int TIMEOUT = 1024
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_msg_valid,
    output logic                     o_msg_ready,
    input  logic [2:0]               i_msg_type,
    input  logic                     i_msg_side,
    input  logic [ID_W-1:0]          i_msg_id,
    input  logic [QTY_W-1:0]         i_msg_size,
    input  logic [PX_W-1:0]          i_msg_limit,
    output logic [NUM_OPS-1:0]       o_op_start,
    output logic                     o_op_side,
    output logic [ID_W-1:0]          o_op_id,
    output logic [QTY_W-1:0]         o_op_size,
    output logic [PX_W-1:0]          o_op_limit,
    input  logic [NUM_OPS-1:0]       i_op_done,
    input  logic [NUM_OPS*RES_W-1:0] i_op_result,
    output logic                     o_res_valid,
    input  logic                     i_res_ready,
    output logic [RES_W-1:0]         o_res_data,
    output logic [1:0]               o_res_status,
    output logic                     o_busy,
    output logic [15:0]              o_cnt_ok,
    output logic [15:0]              o_cnt_err
);
    state_t             r_state, w_state_nxt;
    logic               r_msg_ready, r_res_valid;
    logic [NUM_OPS-1:0] r_op_start;
    logic               r_op_side;
    logic [ID_W-1:0]    r_op_id;
    logic [QTY_W-1:0]   r_op_size;
    logic [PX_W-1:0]    r_op_limit;
    logic [RES_W-1:0]   r_res_data, w_res;
    logic [1:0]         r_res_status;
    logic [15:0]        r_cnt_ok, r_cnt_err;

    logic               w_accept, w_finish_ok, w_finish_to, w_release;
    logic               w_tmr_clr, w_tmr_en, w_expired, w_done, w_type_ok;
    logic [NUM_OPS-1:0] w_start_vec;

    assign w_type_ok   = (int'(i_msg_type) < NUM_OPS);
    assign w_start_vec = NUM_OPS'(1) << i_msg_type;
    // op_start is one-hot, so it doubles as the unit select for done and result.
    assign w_done      = |(i_op_done & r_op_start);

    always_comb begin
        w_res = '0;
        for (int i = 0; i < NUM_OPS; i++)
            if (r_op_start[i]) w_res = w_res | i_op_result[i*RES_W +: RES_W];
    end

    lob_op_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (w_tmr_clr),
        .i_en      (w_tmr_en),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_finish_ok = 1'b0;
        w_finish_to = 1'b0;
        w_release   = 1'b0;
        w_tmr_clr   = 1'b0;
        w_tmr_en    = 1'b0;
        case (r_state)
            S_IDLE: if (i_msg_valid && r_msg_ready) begin
                w_accept = 1'b1;
                if (w_type_ok) begin
                    w_tmr_clr   = 1'b1;
                    w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_RESPOND;
                end
            end
            S_WAIT: begin
                // done is checked first so a simultaneous timeout still reports OK
                if (w_done) begin
                    w_finish_ok = 1'b1;
                    w_state_nxt = S_RESPOND;
                end else if (w_expired) begin
                    w_finish_to = 1'b1;
                    w_state_nxt = S_RESPOND;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            S_RESPOND: if (i_res_ready) begin
                w_release   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_msg_ready  <= 1'b0;
            r_res_valid  <= 1'b0;
            r_op_start   <= '0;
            r_op_side    <= 1'b0;
            r_op_id      <= '0;
            r_op_size    <= '0;
            r_op_limit   <= '0;
            r_res_data   <= '0;
            r_res_status <= ST_OK;
            r_cnt_ok     <= '0;
            r_cnt_err    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_msg_ready <= (w_state_nxt == S_IDLE);
            r_res_valid <= (w_state_nxt == S_RESPOND);
            if (w_accept) begin
                r_op_side  <= i_msg_side;
                r_op_id    <= i_msg_id;
                r_op_size  <= i_msg_size;
                r_op_limit <= i_msg_limit;
                r_op_start <= w_type_ok ? w_start_vec : '0;
                if (!w_type_ok) begin
                    r_res_data   <= '0;
                    r_res_status <= ST_BAD_TYPE;
                end
            end
            if (w_finish_ok) begin
                r_op_start   <= '0;
                r_res_data   <= w_res;
                r_res_status <= ST_OK;
            end
            if (w_finish_to) begin
                r_op_start   <= '0;
                r_res_data   <= '0;
                r_res_status <= ST_TIMEOUT;
            end
            if (w_release) begin
                if (r_res_status == ST_OK) begin
                    if (r_cnt_ok != 16'hFFFF) r_cnt_ok <= r_cnt_ok + 16'd1;
                end else begin
                    if (r_cnt_err != 16'hFFFF) r_cnt_err <= r_cnt_err + 16'd1;
                end
            end
        end
    end

    assign o_msg_ready  = r_msg_ready;
    assign o_res_valid  = r_res_valid;
    assign o_op_start   = r_op_start;
    assign o_op_side    = r_op_side;
    assign o_op_id      = r_op_id;
    assign o_op_size    = r_op_size;
    assign o_op_limit   = r_op_limit;
    assign o_res_data   = r_res_data;
    assign o_res_status = r_res_status;
    assign o_busy       = (r_state != S_IDLE);
    assign o_cnt_ok     = r_cnt_ok;
    assign o_cnt_err    = r_cnt_err;
endmodule

// File: tb/tb_lob_msg_dispatcher.sv
// Directed bench for lob_msg_dispatcher with TIMEOUT=8; expected values are hand-computed.
module tb_lob_msg_dispatcher;
    import lob_pkg::*;

    localparam int NOPS = 6;
    localparam int RW   = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            msg_valid = 1'b0;
    logic            msg_ready;
    logic [2:0]      msg_type = '0;
    logic            msg_side = 1'b0;
    logic [15:0]     msg_id = '0, msg_size = '0, msg_limit = '0;
    logic [NOPS-1:0] op_start;
    logic            op_side;
    logic [15:0]     op_id, op_size, op_limit;
    logic [NOPS-1:0] op_done = '0;
    logic [NOPS*RW-1:0] op_result = '0;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [15:0]     res_data;
    logic [1:0]      res_status;
    logic            busy;
    logic [15:0]     cnt_ok, cnt_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lob_msg_dispatcher #(.NUM_OPS(NOPS), .TIMEOUT(8)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_msg_valid(msg_valid), .o_msg_ready(msg_ready), .i_msg_type(msg_type),
        .i_msg_side(msg_side), .i_msg_id(msg_id), .i_msg_size(msg_size), .i_msg_limit(msg_limit),
        .o_op_start(op_start), .o_op_side(op_side), .o_op_id(op_id), .o_op_size(op_size),
        .o_op_limit(op_limit), .i_op_done(op_done), .i_op_result(op_result),
        .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_data(res_data),
        .o_res_status(res_status), .o_busy(busy), .o_cnt_ok(cnt_ok), .o_cnt_err(cnt_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] t, input logic s, input logic [15:0] id,
                        input logic [15:0] sz, input logic [15:0] lim);
        msg_valid = 1'b1; msg_type = t; msg_side = s;
        msg_id = id; msg_size = sz; msg_limit = lim;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        total++; if (msg_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", msg_ready); end
        total++; if (op_start !== '0 || res_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_outs start=%b rv=%b busy=%b want 0", op_start, res_valid, busy); end
        total++; if (cnt_ok !== 16'd0 || cnt_err !== 16'd0 || res_data !== 16'd0 || res_status !== 2'd0) begin
            bad++; $display("FAIL reset_regs ok=%0d err=%0d data=%h st=%0d want 0", cnt_ok, cnt_err, res_data, res_status); end
        rst = 1'b0;
        tick();
        total++; if (msg_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b want=1", msg_ready); end
    endtask

    task automatic test_basic();
        int hi;
        send(OP_ADD, 1'b1, 16'h0012, 16'd100, 16'd5000);
        op_result[0*RW +: RW] = 16'h0007;
        tick();
        msg_valid = 1'b0;
        total++; if (op_id !== 16'h0012 || op_size !== 16'd100 || op_limit !== 16'd5000 || op_side !== 1'b1) begin
            bad++; $display("FAIL basic_fields id=%h sz=%0d lim=%0d side=%b", op_id, op_size, op_limit, op_side); end
        total++; if (msg_ready !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL basic_busy ready=%b busy=%b want 0/1", msg_ready, busy); end
        hi = 0;
        for (int k = 0; k < 3; k++) begin
            if (op_start === 6'b000001 && res_valid === 1'b0) hi++;
            if (k == 2) op_done = 6'b000001;
            tick();
        end
        op_done = '0;
        total++; if (hi != 3) begin bad++; $display("FAIL basic_start_cycles got=%0d want=3", hi); end
        total++; if (res_valid !== 1'b1 || op_start !== '0 || res_data !== 16'h0007 || res_status !== ST_OK) begin
            bad++; $display("FAIL basic_resp rv=%b start=%b data=%h st=%0d want 1/0/0007/0", res_valid, op_start, res_data, res_status); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        total++; if (res_valid !== 1'b0 || msg_ready !== 1'b1 || busy !== 1'b0 || cnt_ok !== 16'd1) begin
            bad++; $display("FAIL basic_release rv=%b rdy=%b busy=%b ok=%0d want 0/1/0/1", res_valid, msg_ready, busy, cnt_ok); end
    endtask

    task automatic test_bad_type();
        send(3'd6, 1'b0, 16'h0001, 16'd1, 16'd1);
        tick();
        msg_valid = 1'b0;
        total++; if (op_start !== '0 || res_valid !== 1'b1 || res_data !== 16'h0000 || res_status !== ST_BAD_TYPE) begin
            bad++; $display("FAIL bad_type start=%b rv=%b data=%h st=%0d want 0/1/0000/1", op_start, res_valid, res_data, res_status); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        total++; if (cnt_err !== 16'd1 || cnt_ok !== 16'd1 || msg_ready !== 1'b1) begin
            bad++; $display("FAIL bad_type_cnt err=%0d ok=%0d rdy=%b want 1/1/1", cnt_err, cnt_ok, msg_ready); end
    endtask

    task automatic test_zero_result();
        op_result[4*RW +: RW] = 16'h0000;
        send(OP_BEST_LIMIT, 1'b0, 16'h0044, 16'd4, 16'd44);
        tick();
        msg_valid = 1'b0;
        total++; if (op_start !== 6'b010000) begin bad++; $display("FAIL zero_start got=%b want=010000", op_start); end
        op_done = 6'b010000;
        tick();
        op_done = '0;
        total++; if (res_valid !== 1'b1 || res_data !== 16'h0000 || res_status !== ST_OK) begin
            bad++; $display("FAIL zero_resp rv=%b data=%h st=%0d want 1/0000/0", res_valid, res_data, res_status); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        total++; if (busy !== 1'b0 || msg_ready !== 1'b1 || cnt_ok !== 16'd2) begin
            bad++; $display("FAIL zero_release busy=%b rdy=%b ok=%0d want 0/1/2", busy, msg_ready, cnt_ok); end
    endtask

    task automatic test_ignore_other();
        op_result[1*RW +: RW] = 16'h1111;
        op_result[3*RW +: RW] = 16'h3333;
        send(OP_EXECUTE, 1'b1, 16'h0101, 16'd10, 16'd20);
        tick();
        msg_valid = 1'b0;
        op_done = 6'b001000;
        tick(); tick();
        total++; if (res_valid !== 1'b0 || op_start !== 6'b000010) begin
            bad++; $display("FAIL ignore_other rv=%b start=%b want 0/000010", res_valid, op_start); end
        op_done = 6'b000010;
        tick();
        op_done = '0;
        total++; if (res_valid !== 1'b1 || res_data !== 16'h1111 || res_status !== ST_OK) begin
            bad++; $display("FAIL ignore_resp rv=%b data=%h st=%0d want 1/1111/0", res_valid, res_data, res_status); end
        send(OP_ADD, 1'b0, 16'h0999, 16'd9, 16'd9);
        for (int k = 0; k < 5; k++) begin
            tick();
            total++; if (res_valid !== 1'b1 || res_data !== 16'h1111 || msg_ready !== 1'b0 || op_start !== '0) begin
                bad++; $display("FAIL hold_cycle%0d rv=%b data=%h rdy=%b start=%b", k, res_valid, res_data, msg_ready, op_start); end
        end
        msg_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        total++; if (cnt_ok !== 16'd3 || msg_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL ignore_release ok=%0d rdy=%b busy=%b want 3/1/0", cnt_ok, msg_ready, busy); end
    endtask

    task automatic test_timeout();
        int hi, lat;
        op_result[2*RW +: RW] = 16'hBEEF;
        send(OP_CANCEL, 1'b0, 16'h0202, 16'd2, 16'd2);
        tick();
        msg_valid = 1'b0;
        hi = 0; lat = -1;
        for (int k = 0; k < 20; k++) begin
            if (op_start === 6'b000100) hi++;
            if (res_valid === 1'b1) begin lat = k; break; end
            tick();
        end
        total++; if (hi != 8) begin bad++; $display("FAIL timeout_start_cycles got=%0d want=8", hi); end
        total++; if (lat != 8) begin bad++; $display("FAIL timeout_latency got=%0d want=8", lat); end
        total++; if (res_status !== ST_TIMEOUT || res_data !== 16'h0000 || op_start !== '0) begin
            bad++; $display("FAIL timeout_resp st=%0d data=%h start=%b want 2/0000/0", res_status, res_data, op_start); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        total++; if (cnt_err !== 16'd2 || cnt_ok !== 16'd3) begin
            bad++; $display("FAIL timeout_cnt err=%0d ok=%0d want 2/3", cnt_err, cnt_ok); end
    endtask

    task automatic test_done_at_timeout();
        op_result[5*RW +: RW] = 16'h5555;
        send(OP_VOLUME, 1'b1, 16'h0505, 16'd5, 16'd5);
        tick();
        msg_valid = 1'b0;
        repeat (7) tick();
        total++; if (res_valid !== 1'b0 || op_start !== 6'b100000) begin
            bad++; $display("FAIL edge_wait rv=%b start=%b want 0/100000", res_valid, op_start); end
        op_done = 6'b100000;
        tick();
        op_done = '0;
        total++; if (res_valid !== 1'b1 || res_status !== ST_OK || res_data !== 16'h5555) begin
            bad++; $display("FAIL edge_done_wins rv=%b st=%0d data=%h want 1/0/5555", res_valid, res_status, res_data); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        total++; if (cnt_ok !== 16'd4) begin bad++; $display("FAIL edge_cnt ok=%0d want=4", cnt_ok); end
    endtask

    task automatic test_back_to_back();
        op_result[0*RW +: RW] = 16'hA0A0;
        op_result[3*RW +: RW] = 16'hD3D3;
        op_done   = 6'b111111;
        res_ready = 1'b1;
        send(OP_ADD, 1'b0, 16'h0001, 16'd1, 16'd1);
        tick();
        msg_type = OP_DELETE;
        total++; if (op_start !== 6'b000001) begin bad++; $display("FAIL b2b_start0 got=%b want=000001", op_start); end
        tick();
        total++; if (res_valid !== 1'b1 || res_data !== 16'hA0A0 || msg_ready !== 1'b0) begin
            bad++; $display("FAIL b2b_resp0 rv=%b data=%h rdy=%b want 1/a0a0/0", res_valid, res_data, msg_ready); end
        tick();
        total++; if (res_valid !== 1'b0 || msg_ready !== 1'b1 || op_start !== '0) begin
            bad++; $display("FAIL b2b_idle rv=%b rdy=%b start=%b want 0/1/0", res_valid, msg_ready, op_start); end
        tick();
        msg_valid = 1'b0;
        total++; if (op_start !== 6'b001000) begin bad++; $display("FAIL b2b_start3 got=%b want=001000", op_start); end
        tick();
        total++; if (res_valid !== 1'b1 || res_data !== 16'hD3D3) begin
            bad++; $display("FAIL b2b_resp3 rv=%b data=%h want 1/d3d3", res_valid, res_data); end
        tick();
        op_done = '0;
        res_ready = 1'b0;
        total++; if (cnt_ok !== 16'd6 || busy !== 1'b0) begin
            bad++; $display("FAIL b2b_cnt ok=%0d busy=%b want 6/0", cnt_ok, busy); end
    endtask

    task automatic test_reset_mid_wait();
        send(OP_CANCEL, 1'b0, 16'h0777, 16'd7, 16'd7);
        tick();
        msg_valid = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        total++; if (op_start !== '0 || busy !== 1'b0 || res_valid !== 1'b0 || msg_ready !== 1'b0) begin
            bad++; $display("FAIL async_reset start=%b busy=%b rv=%b rdy=%b want 0", op_start, busy, res_valid, msg_ready); end
        total++; if (cnt_ok !== 16'd0) begin bad++; $display("FAIL async_reset_cnt ok=%0d want=0", cnt_ok); end
        tick();
        rst = 1'b0;
        tick();
        op_result[0*RW +: RW] = 16'h0042;
        send(OP_ADD, 1'b0, 16'h0003, 16'd3, 16'd3);
        tick();
        msg_valid = 1'b0;
        total++; if (op_start !== 6'b000001 || op_id !== 16'h0003) begin
            bad++; $display("FAIL after_reset_accept start=%b id=%h want 000001/0003", op_start, op_id); end
        op_done = 6'b000001;
        tick();
        op_done = '0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        total++; if (cnt_ok !== 16'd1 || res_data !== 16'h0042) begin
            bad++; $display("FAIL after_reset_resp ok=%0d data=%h want 1/0042", cnt_ok, res_data); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_type();
        test_zero_result();
        test_ignore_other();
        test_timeout();
        test_done_at_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end
endmodule
